// File: rtl/sub_sequencer.sv
// sub_sequencer: multi-cycle subtractor. A single 4-bit subtract slice is
// reused for NIBBLES cycles, least-significant nibble first. The borrow is
// carried from one cycle to the next, so a-b takes NIBBLES cycles to finish.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last completed result
// S_RUN  | one nibble per cycle, borrow chained through r_bin
// S_DONE | results valid, done pulses for one cycle, then back to idle
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin one subtraction (sampled only in S_IDLE)
//   a, b       minuend / subtrahend, captured when start is accepted
//   busy       high in S_RUN and S_DONE
//   done       one-cycle pulse when the result is valid
//   difference a-b modulo 2^W
//   borrow     1 iff a < b (unsigned)
//   zero       difference == 0
//   overflow   two's-complement overflow of a-b
module sub_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   difference,
  output logic                   borrow,
  output logic                   zero,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_diff;
  logic [IW-1:0]   r_idx;
  logic            r_bin;
  logic            r_borrow;
  logic            r_zero;
  logic            r_ovf;

  logic            w_last;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_slice;
  logic [W-1:0]    w_diff_next;
  logic            w_ovf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // 5-bit subtract: bit 4 is set exactly when a_n < b_n + bin.
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
  assign w_slice = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_bin};

  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[{r_idx, 2'b00} +: 4] = w_slice[3:0];
  end

  // Flags are taken from the full result that lands on the last RUN edge.
  assign w_ovf_next = (r_a[W-1] != r_b[W-1]) && (w_diff_next[W-1] != r_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_bin <= 1'b0;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_diff <= w_diff_next;
          r_bin  <= w_slice[4];
          if (w_last) begin
            r_borrow <= w_slice[4];
            r_zero   <= (w_diff_next == '0);
            r_ovf    <= w_ovf_next;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign difference = r_diff;
  assign borrow     = r_borrow;
  assign zero       = r_zero;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_sub_sequencer.sv
module tb_sub_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] difference;
  logic        borrow;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sub_sequencer #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow     (borrow),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and walk cycles 1..6 after the accepting edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] exp_d, input logic eb,
                        input logic ez, input logic eo, input string name);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
      end
      n_checks++;
      if (done !== (k == 5)) begin
        n_fail++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, k, done, (k == 5));
      end
      n_checks++;
      if (busy !== (k <= 5)) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy, (k <= 5));
      end
      if (k >= 5) begin
        n_checks++;
        if ({difference, borrow, zero, overflow} !== {exp_d, eb, ez, eo}) begin
          n_fail++;
          $display("FAIL %s result cycle %0d: got d=%h b=%b z=%b o=%b expected d=%h b=%b z=%b o=%b",
                   name, k, difference, borrow, zero, overflow, exp_d, eb, ez, eo);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, difference, borrow, zero, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%h b=%b z=%b o=%b expected all 0",
               busy, done, difference, borrow, zero, overflow);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run_op(16'h0004, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, "basic_4m2");
  endtask

  task automatic test_borrow;
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, "borrow_0m1");
    run_op(16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0, "borrow_chain");
  endtask

  task automatic test_overflow_zero;
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, "overflow");
    run_op(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, "zero");
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    @(negedge clk);
    a = 16'h0009; b = 16'h0003; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; a = 16'hFFFF; end
      if (k == 3) start = 1'b0;
      if (done === 1'b1) dones++;
      if (k >= 5) begin
        n_checks++;
        if (difference !== 16'h0006) begin
          n_fail++;
          $display("FAIL ignore_diff cycle %0d: got %h expected 0006", k, difference);
        end
      end
      if (k >= 6) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_not_queued cycle %0d: busy got %b expected 0", k, busy);
        end
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    a = 16'h0009; b = 16'h0003; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, difference, borrow, zero, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b d=%h b=%b z=%b o=%b expected all 0",
               busy, done, difference, borrow, zero, overflow);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: got done=%b busy=%b expected 0 0", done, busy);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea [3];
    logic [15:0] eb [3];
    logic [15:0] ed [3];
    logic        ebr [3];
    logic        eov [3];
    int          op;
    ea[0] = 16'h1000; eb[0] = 16'h0001; ed[0] = 16'h0FFF; ebr[0] = 1'b0; eov[0] = 1'b0;
    ea[1] = 16'h0001; eb[1] = 16'h0002; ed[1] = 16'hFFFF; ebr[1] = 1'b1; eov[1] = 1'b0;
    ea[2] = 16'h7FFF; eb[2] = 16'hFFFF; ed[2] = 16'h8000; ebr[2] = 1'b1; eov[2] = 1'b1;
    @(negedge clk);
    a = ea[0]; b = eb[0]; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin a = ea[1]; b = eb[1]; end
      if (k == 7) begin a = ea[2]; b = eb[2]; end
      if (k == 13) begin start = 1'b0; a = 16'h5555; b = 16'hAAAA; end
      n_checks++;
      if (done !== (k == 5 || k == 11 || k == 17)) begin
        n_fail++;
        $display("FAIL b2b_done cycle %0d: got %b expected %b", k, done,
                 (k == 5 || k == 11 || k == 17));
      end
      if (k == 5 || k == 11 || k == 17) begin
        op = (k - 5) / 6;
        n_checks++;
        if ({difference, borrow, zero, overflow} !== {ed[op], ebr[op], 1'b0, eov[op]}) begin
          n_fail++;
          $display("FAIL b2b_result op %0d: got d=%h b=%b z=%b o=%b expected d=%h b=%b z=0 o=%b",
                   op, difference, borrow, zero, overflow, ed[op], ebr[op], eov[op]);
        end
      end
      if (k == 6 || k == 12) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle cycle %0d: busy got %b expected 0", k, busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub_sequencer.md
SUB_SEQUENCER -- requirements
Module: sub_sequencer

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 a  input  W  minuend; captured on the accepted start.
REQ-006 b  input  W  subtrahend; captured on the accepted start.
REQ-007 busy  output  1  high in RUN and DONE; low in IDLE.
REQ-008 done  output  1  one-cycle pulse when results become valid.
REQ-009 difference  output  W  result a-b modulo 2^W.
REQ-010 borrow  output  1  final slice borrow-out: 1 iff a < b unsigned.
REQ-011 zero  output  1  difference == 0.
REQ-012 overflow  output  1  two's-complement overflow of a-b.

Function
REQ-013 The block SHALL time-share a single 4-bit subtract slice across NIBBLES cycles, least-significant nibble first, chaining the borrow between cycles.
REQ-014 Slice arithmetic SHALL be: d = (a_n - b_n - bin) mod 16; bout = 1 iff a_n < b_n + bin (unsigned, 5-bit compare). Use of the team's 4-bit subtraction unit is allowed if it is bit-equivalent to this rule.
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at a clock edge SHALL capture a and b, clear the internal borrow and nibble index, and go to RUN.
REQ-017 Each RUN cycle SHALL compute nibble index i, write d into difference[4i+3:4i], register bout and increment i.
REQ-018 After nibble NIBBLES-1 is written, the FSM SHALL go to DONE and update borrow, zero and overflow on that same edge.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: if start is sampled at edge E0, done SHALL be high in the cycle after edge E0+NIBBLES (5 cycles for NIBBLES=4).
REQ-021 The index counter SHALL be ceil(log2(NIBBLES)) bits wide, with a minimum of 1 bit, and SHALL not wrap within an operation.
REQ-022 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-023 Changes on a or b after capture SHALL not affect the result.
REQ-024 overflow SHALL equal (a[W-1] != b[W-1]) && (difference[W-1] != a[W-1]), using the captured operands.
REQ-025 difference and the flags SHALL hold their last completed values until the next accepted start.
REQ-026 During RUN, difference MAY show partially updated nibbles; consumers SHALL qualify difference with done.
REQ-027 start held high continuously SHALL launch back-to-back operations, each accepted in IDLE, one every NIBBLES+2 cycles.

Reset
REQ-028 When rst_n=0, the block SHALL force immediately, without waiting for clk: state=IDLE, busy=0, done=0, difference=0, borrow=0, zero=0, overflow=0, index=0, internal borrow=0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-031 a=0x0004, b=0x0002, start pulse -> busy high next cycle; done in cycle 5; difference=0x0002; borrow=0, zero=0, overflow=0.
REQ-032 a=0x0000, b=0x0001 -> difference=0xFFFF, borrow=1, overflow=0, zero=0; also a=0x0100, b=0x0001 -> difference=0x00FF, checking borrow propagation across nibbles 0-2.
REQ-033 a=0x8000, b=0x0001 -> difference=0x7FFF, overflow=1, borrow=0; then a=0x1234, b=0x1234 -> difference=0x0000, zero=1.
REQ-034 Start a=0x0009, b=0x0003; pulse start with a=0xFFFF in cycle 2 -> only one done; difference=0x0006; the second start is not queued; outputs stay stable until the next start.
REQ-035 Drop rst_n in cycle 3 of RUN -> all outputs 0 immediately, no done; after release, a=0x0005, b=0x0005 -> zero=1 in cycle 5.
REQ-036 start tied high for 3 operations -> done pulses exactly NIBBLES+2 cycles apart, with each result correct against a reference model.
